gate_exerciser: RTL and testbench

// - Drives the two inputs of a 2-input gate under test, such as or_gate, through all four {a,b} combinations.
// - Waits a settle interval after each combination, samples the gate output f and checks it against a programmable truth table.
// - Reports pass/fail plus a per-vector failure map; it is the stimulus/check end of the gate's a,b -> f interface.
// - Used on-board with switches/LEDs or in simulation as a self-checking harness.

---
 rtl/gate_exerciser.sv | 111 +++++++++++
 tb/tb_gate_exerciser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// Stimulus/check harness for a 2-input gate: sweeps {a,b} through 00..11, waits
// a settle interval per vector and scores the gate output against EXP_TT.
module gate_exerciser #(
    parameter logic [3:0]  EXP_TT        = 4'b1110,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       f_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_vecIdx;
    logic [7:0] r_settleCnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_failVec;
    logic [2:0] r_errCnt;

    // The settle counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly
    // SETTLE_CYCLES cycles; pass in FINISH sees the count already updated by the last SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vecIdx    <= 2'd0;
            r_settleCnt <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_failVec   <= 4'd0;
            r_errCnt    <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= APPLY;
                        r_failVec <= 4'd0;
                        r_errCnt  <= 3'd0;
                        r_pass    <= 1'b0;
                        r_vecIdx  <= 2'd0;
                        r_busy    <= 1'b1;
                    end
                end
                APPLY: begin
                    {r_a, r_b}  <= r_vecIdx;
                    r_settleCnt <= SETTLE_LOAD;
                    r_state     <= SETTLE;
                end
                SETTLE: begin
                    if (r_settleCnt == 8'd0) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settleCnt <= r_settleCnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (f_in != EXP_TT[r_vecIdx]) begin
                        r_failVec[r_vecIdx] <= 1'b1;
                        r_errCnt            <= r_errCnt + 3'd1;
                    end
                    if (r_vecIdx == 2'd3) begin
                        r_state <= FINISH;
                    end else begin
                        r_vecIdx <= r_vecIdx + 2'd1;
                        r_state  <= APPLY;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_errCnt == 3'd0);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_out    = r_a;
    assign b_out    = r_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_vec = r_failVec;
    assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench: stimulus pushes expected sweep results, a negedge monitor
// pops and checks them on every done pulse (two DUTs: default and SETTLE_CYCLES=1).
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       a0, b0, a1, b1;
    logic       f0, f1, fDly0, fDly1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] fv0, fv1;
    logic [2:0] ec0, ec1;
    int         fMode;

    always #5 clk = ~clk;

    gate_exerciser dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .err_cnt(ec0)
    );

    gate_exerciser #(.EXP_TT(4'b1110), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .err_cnt(ec1)
    );

    // Gate models: 0 = OR, 1 = stuck-at-0, 2 = AND, 3 = OR with one register of delay.
    always_comb begin
        case (fMode)
            0:       f0 = a0 | b0;
            1:       f0 = 1'b0;
            2:       f0 = a0 & b0;
            default: f0 = fDly0;
        endcase
    end

    always @(posedge clk) begin
        fDly0 <= a0 | b0;
        fDly1 <= a1 | b1;
    end
    assign f1 = fDly1;

    typedef struct {
        int         dut;
        logic       pass;
        logic [3:0] fv;
        logic [2:0] ec;
        int         lat;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor state: cycles since busy rose, and the {a,b} values seen mid-vector.
    int         monCnt[2];
    bit         monActive[2];
    logic       monPrevBusy[2];
    logic [7:0] monSeq[2];

    initial begin
        monActive   = '{0, 0};
        monPrevBusy = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic       bsy, dn, ps;
                logic [1:0] ab;
                logic [3:0] fv;
                logic [2:0] ec;
                int         per;
                exp_t       e;
                bsy = (d == 0) ? busy0 : busy1;
                dn  = (d == 0) ? done0 : done1;
                ps  = (d == 0) ? pass0 : pass1;
                ab  = (d == 0) ? {a0, b0} : {a1, b1};
                fv  = (d == 0) ? fv0 : fv1;
                ec  = (d == 0) ? ec0 : ec1;
                per = (d == 0) ? 6 : 3;
                if (rst === 1'b1) begin
                    monActive[d] = 0;
                end else if (bsy === 1'b1 && monPrevBusy[d] !== 1'b1) begin
                    monActive[d] = 1;
                    monCnt[d]    = 0;
                    monSeq[d]    = 8'h00;
                end else if (monActive[d]) begin
                    monCnt[d]++;
                end
                monPrevBusy[d] = bsy;
                if (monActive[d] && monCnt[d] >= 2 && monCnt[d] <= 2 + 3 * per &&
                    (monCnt[d] - 2) % per == 0) begin
                    monSeq[d] = {monSeq[d][5:0], ab};
                end
                if (dn === 1'b1) begin
                    if (expQ.size() == 0 || expQ[0].dut != d) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_done: dut%0d got done=1, required none", d);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pass", 32'(ps), 32'(e.pass));
                        checkOutput("fail_vec", 32'(fv), 32'(e.fv));
                        checkOutput("err_cnt", 32'(ec), 32'(e.ec));
                        checkOutput("latency", 32'(monCnt[d] + 1), 32'(e.lat));
                        checkOutput("ab_sequence", 32'(monSeq[d]), 32'h1B);
                    end
                    monActive[d] = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic ps, input logic [3:0] fv,
                                 input logic [2:0] ec, input int lat);
        exp_t e;
        e.dut = d; e.pass = ps; e.fv = fv; e.ec = ec; e.lat = lat;
        expQ.push_back(e);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulseStart0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: %0d sweeps outstanding, required 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("rst_a_out", 32'(a0), 32'h0);
        checkOutput("rst_b_out", 32'(b0), 32'h0);
        checkOutput("rst_busy", 32'(busy0), 32'h0);
        checkOutput("rst_done", 32'(done0), 32'h0);
        checkOutput("rst_pass", 32'(pass0), 32'h0);
        checkOutput("rst_fail_vec", 32'(fv0), 32'h0);
        checkOutput("rst_err_cnt", 32'(ec0), 32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        fMode  = 0;
        repeat (2) @(negedge clk);
        checkResetState();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // OR gate, stuck-at-0 and AND gate against the OR truth table
        fMode = 0;
        applyStimulus(0, 1'b1, 4'b0000, 3'd0, 26);
        waitDone();
        checkOutput("ab_hold_after_sweep", 32'({a0, b0}), 32'h3);
        fMode = 1;
        applyStimulus(0, 1'b0, 4'b1110, 3'd3, 26);
        waitDone();
        fMode = 2;
        applyStimulus(0, 1'b0, 4'b0110, 3'd2, 26);
        waitDone();

        // Reset during SETTLE of vector 2 aborts silently
        fMode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus(0, 1'b1, 4'b0000, 3'd0, 26);
        waitDone();

        // start re-pulsed at cycles 5 and 12 of a sweep is ignored
        applyStimulus(0, 1'b1, 4'b0000, 3'd0, 26);
        repeat (4) @(negedge clk);
        pulseStart0();
        repeat (6) @(negedge clk);
        pulseStart0();
        waitDone();
        repeat (40) @(negedge clk);

        // Registered-delay gate with minimum and default settle intervals
        applyStimulus(1, 1'b1, 4'b0000, 3'd0, 14);
        waitDone();
        fMode = 3;
        applyStimulus(0, 1'b1, 4'b0000, 3'd0, 26);
        waitDone();
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
